jtag_tap_responder: RTL and testbench

- IEEE 1149.1-style TAP responder (target side) in the CPLD, answering a JTAG master such as the FT channel MPSSE engine.
- Used to loop back and self-test the JTAG master path through JP2, without an external target.
- TCK/TMS/TDI/nTRST are oversampled on the system clock; there is no TCK clock domain.
- Provides IDCODE, BYPASS and one user data register with a parallel capture/update interface.

---
 rtl/jtag_tap_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_jtag_tap_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1-style TAP target with IDCODE, BYPASS and a USER data register,
// all JTAG pins oversampled on CLK. Optional macro JTAG_TRST_EN enables nTRST_IN.
module jtag_tap_responder #(
  parameter int unsigned     IR_W       = 4,
  parameter logic [31:0]     IDCODE_VAL = 32'h0B1A5001,
  parameter int unsigned     USER_W     = 8,
  parameter logic [IR_W-1:0] OP_IDCODE  = IR_W'(1),
  parameter logic [IR_W-1:0] OP_USER    = IR_W'(2)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              TCK_IN,
  input  logic              TMS_IN,
  input  logic              TDI_IN,
  input  logic              nTRST_IN,
  output logic              TDO_OUT,
  output logic              TDO_OE,
  output logic [3:0]        TAP_STATE,
  input  logic [USER_W-1:0] USER_DIN,
  output logic [USER_W-1:0] USER_DOUT,
  output logic              USER_UPDATE
);

  typedef enum logic [3:0] {
    ST_TLR    = 4'd0,
    ST_RTI    = 4'd1,
    ST_SEL_DR = 4'd2,
    ST_CAP_DR = 4'd3,
    ST_SH_DR  = 4'd4,
    ST_EX1_DR = 4'd5,
    ST_PAU_DR = 4'd6,
    ST_EX2_DR = 4'd7,
    ST_UPD_DR = 4'd8,
    ST_SEL_IR = 4'd9,
    ST_CAP_IR = 4'd10,
    ST_SH_IR  = 4'd11,
    ST_EX1_IR = 4'd12,
    ST_PAU_IR = 4'd13,
    ST_EX2_IR = 4'd14,
    ST_UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e        r_state;
  tap_state_e        w_state_nxt;

  logic              r_tck_s1, r_tck_s2, r_tck_s3;
  logic              r_tms_s1, r_tms_s2;
  logic              r_tdi_s1, r_tdi_s2;
  logic              w_rise, w_fall, w_trst;

  logic [IR_W-1:0]   r_ir_sr, r_ir;
  logic [31:0]       r_id_sr;
  logic [USER_W-1:0] r_user_sr, r_user_dout;
  logic              r_byp_sr, r_user_upd;
  logic              r_tdo, r_tdo_oe;

  logic              w_sel_id, w_sel_user, w_dr_lsb;
  logic              w_sh_ir, w_sh_dr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_tck_s1 <= 1'b0;
      r_tck_s2 <= 1'b0;
      r_tck_s3 <= 1'b0;
      r_tms_s1 <= 1'b0;
      r_tms_s2 <= 1'b0;
      r_tdi_s1 <= 1'b0;
      r_tdi_s2 <= 1'b0;
    end else begin
      r_tck_s1 <= TCK_IN;
      r_tck_s2 <= r_tck_s1;
      r_tck_s3 <= r_tck_s2;
      r_tms_s1 <= TMS_IN;
      r_tms_s2 <= r_tms_s1;
      r_tdi_s1 <= TDI_IN;
      r_tdi_s2 <= r_tdi_s1;
    end
  end

  assign w_rise = r_tck_s2 & ~r_tck_s3;
  assign w_fall = ~r_tck_s2 & r_tck_s3;

`ifdef JTAG_TRST_EN
  logic r_trst_n_s1, r_trst_n_s2;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_trst_n_s1 <= 1'b0;
      r_trst_n_s2 <= 1'b0;
    end else begin
      r_trst_n_s1 <= nTRST_IN;
      r_trst_n_s2 <= r_trst_n_s1;
    end
  end

  assign w_trst = ~r_trst_n_s2;
`else
  logic w_unused_trst;
  assign w_unused_trst = nTRST_IN;
  assign w_trst        = 1'b0;
`endif

  // TAP controller: state register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= ST_TLR;
    else       r_state <= w_state_nxt;
  end

  // TAP controller: next state, advancing only on a synced TCK rise
  always_comb begin
    w_state_nxt = r_state;
    if (w_trst) begin
      w_state_nxt = ST_TLR;
    end else if (w_rise) begin
      case (r_state)
        ST_TLR:    w_state_nxt = r_tms_s2 ? ST_TLR    : ST_RTI;
        ST_RTI:    w_state_nxt = r_tms_s2 ? ST_SEL_DR : ST_RTI;
        ST_SEL_DR: w_state_nxt = r_tms_s2 ? ST_SEL_IR : ST_CAP_DR;
        ST_CAP_DR: w_state_nxt = r_tms_s2 ? ST_EX1_DR : ST_SH_DR;
        ST_SH_DR:  w_state_nxt = r_tms_s2 ? ST_EX1_DR : ST_SH_DR;
        ST_EX1_DR: w_state_nxt = r_tms_s2 ? ST_UPD_DR : ST_PAU_DR;
        ST_PAU_DR: w_state_nxt = r_tms_s2 ? ST_EX2_DR : ST_PAU_DR;
        ST_EX2_DR: w_state_nxt = r_tms_s2 ? ST_UPD_DR : ST_SH_DR;
        ST_UPD_DR: w_state_nxt = r_tms_s2 ? ST_SEL_DR : ST_RTI;
        ST_SEL_IR: w_state_nxt = r_tms_s2 ? ST_TLR    : ST_CAP_IR;
        ST_CAP_IR: w_state_nxt = r_tms_s2 ? ST_EX1_IR : ST_SH_IR;
        ST_SH_IR:  w_state_nxt = r_tms_s2 ? ST_EX1_IR : ST_SH_IR;
        ST_EX1_IR: w_state_nxt = r_tms_s2 ? ST_UPD_IR : ST_PAU_IR;
        ST_PAU_IR: w_state_nxt = r_tms_s2 ? ST_EX2_IR : ST_PAU_IR;
        ST_EX2_IR: w_state_nxt = r_tms_s2 ? ST_UPD_IR : ST_SH_IR;
        ST_UPD_IR: w_state_nxt = r_tms_s2 ? ST_SEL_DR : ST_RTI;
        default:   w_state_nxt = ST_TLR;
      endcase
    end
  end

  // TAP controller: state decodes
  always_comb begin
    TAP_STATE = r_state;
    w_sh_ir   = (r_state == ST_SH_IR);
    w_sh_dr   = (r_state == ST_SH_DR);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ir_sr <= '0;
      r_ir    <= OP_IDCODE;
    end else if (w_trst) begin
      r_ir    <= OP_IDCODE;
    end else if (w_rise) begin
      case (r_state)
        ST_TLR:    r_ir    <= OP_IDCODE;
        ST_CAP_IR: r_ir_sr <= IR_W'(1);
        ST_SH_IR:  r_ir_sr <= {r_tdi_s2, r_ir_sr[IR_W-1:1]};
        ST_UPD_IR: r_ir    <= r_ir_sr;
        default:   ;
      endcase
    end
  end

  // IDCODE takes priority should OP_USER ever be configured equal to it
  assign w_sel_id   = (r_ir == OP_IDCODE);
  assign w_sel_user = (r_ir == OP_USER) && !w_sel_id;

  always_comb begin
    w_dr_lsb = r_byp_sr;
    if (w_sel_id)        w_dr_lsb = r_id_sr[0];
    else if (w_sel_user) w_dr_lsb = r_user_sr[0];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_id_sr     <= '0;
      r_user_sr   <= '0;
      r_byp_sr    <= 1'b0;
      r_user_dout <= '0;
      r_user_upd  <= 1'b0;
    end else begin
      r_user_upd <= 1'b0;
      if (w_rise && !w_trst) begin
        case (r_state)
          ST_CAP_DR: begin
            if (w_sel_id)        r_id_sr   <= IDCODE_VAL;
            else if (w_sel_user) r_user_sr <= USER_DIN;
            else                 r_byp_sr  <= 1'b0;
          end
          ST_SH_DR: begin
            if (w_sel_id)        r_id_sr   <= {r_tdi_s2, r_id_sr[31:1]};
            else if (w_sel_user) r_user_sr <= {r_tdi_s2, r_user_sr[USER_W-1:1]};
            else                 r_byp_sr  <= r_tdi_s2;
          end
          ST_UPD_DR: begin
            if (w_sel_user) begin
              r_user_dout <= r_user_sr;
              r_user_upd  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // TDO launches on the falling edge so the master can sample it on the next rise
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else if (w_trst) begin
      r_tdo_oe <= 1'b0;
    end else if (w_fall) begin
      if (w_sh_ir) begin
        r_tdo    <= r_ir_sr[0];
        r_tdo_oe <= 1'b1;
      end else if (w_sh_dr) begin
        r_tdo    <= w_dr_lsb;
        r_tdo_oe <= 1'b1;
      end else begin
        r_tdo_oe <= 1'b0;
      end
    end
  end

  assign TDO_OUT     = r_tdo;
  assign TDO_OE      = r_tdo_oe;
  assign USER_DOUT   = r_user_dout;
  assign USER_UPDATE = r_user_upd;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Scoreboard bench for jtag_tap_responder: randomized scans against a
// bit-stream reference model of the TAP and its data registers.
`timescale 1ns/1ps
module tb_jtag_tap_responder;

  localparam int unsigned     IR_W   = 4;
  localparam int unsigned     USER_W = 8;
  localparam logic [31:0]     IDV    = 32'h0B1A5001;
  localparam logic [IR_W-1:0] OP_ID  = 4'b0001;
  localparam logic [IR_W-1:0] OP_USR = 4'b0010;
  localparam int unsigned     HALF   = 6;

  // Standard 1149.1 graph as lookup tables, indexed by state code
  localparam int NXT0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  localparam int NXT1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              TCK_IN = 1'b0, TMS_IN = 1'b0, TDI_IN = 1'b0, nTRST_IN = 1'b1;
  logic              TDO_OUT, TDO_OE, USER_UPDATE;
  logic [3:0]        TAP_STATE;
  logic [USER_W-1:0] USER_DIN = '0;
  logic [USER_W-1:0] USER_DOUT;

  jtag_tap_responder #(
    .IR_W(IR_W), .IDCODE_VAL(IDV), .USER_W(USER_W), .OP_IDCODE(OP_ID), .OP_USER(OP_USR)
  ) dut (
    .CLK(CLK), .nRST(nRST), .TCK_IN(TCK_IN), .TMS_IN(TMS_IN), .TDI_IN(TDI_IN),
    .nTRST_IN(nTRST_IN), .TDO_OUT(TDO_OUT), .TDO_OE(TDO_OE), .TAP_STATE(TAP_STATE),
    .USER_DIN(USER_DIN), .USER_DOUT(USER_DOUT), .USER_UPDATE(USER_UPDATE)
  );

  always #5 CLK = ~CLK;

  int unsigned       n_pass = 0, n_tot = 0;
  int unsigned       upd_cnt = 0;
  bit                exp_q[$];
  bit                scb_en = 1'b1;

  int                m_st = 0;
  logic [IR_W-1:0]   m_ir = OP_ID;
  logic [USER_W-1:0] m_dout = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge CLK) if (USER_UPDATE) upd_cnt++;

  // Monitor: every TCK rise with TDO enabled consumes one expected bit
  initial begin
    bit b;
    forever begin
      @(posedge TCK_IN);
      if (scb_en && TDO_OE) begin
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL tdo_extra: TDO_OE=1 (TDO=%0b) with no bit expected at %0t", TDO_OUT, $time);
        end else begin
          b = exp_q.pop_front();
          check("tdo_bit", TDO_OUT, b);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tck(input bit tms, input bit tdi);
    TMS_IN = tms;
    TDI_IN = tdi;
    repeat (HALF) @(negedge CLK);
    TCK_IN = 1'b1;
    if (m_st == 0) m_ir = OP_ID;
    m_st = tms ? NXT1[m_st] : NXT0[m_st];
    repeat (HALF) @(negedge CLK);
    TCK_IN = 1'b0;
    check("tap_state", TAP_STATE, m_st);
  endtask

  task automatic goto_rti();
    for (int unsigned i = 0; i < 5; i++) tck(1'b1, 1'b0);
    check("tlr_reached", TAP_STATE, 0);
    tck(1'b0, 1'b0);
  endtask

  function automatic bit stream_bit(input int i, input int len, input logic [63:0] v,
                                    input logic [63:0] d);
    return (i < len) ? v[i] : d[i - len];
  endfunction

  task automatic scan_ir(input logic [IR_W-1:0] val);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < int'(IR_W); i++) begin
      exp_q.push_back(i == 0);
      tck(i == int'(IR_W) - 1, val[i]);
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    m_ir = val;
    check("ir_q_drained", exp_q.size(), 0);
  endtask

  // Shift n bits of d through the selected DR; optional pause after bit pause_at,
  // optional nRST abort before bit abort_at.
  task automatic scan_dr(input int n, input logic [63:0] d, input int pause_at,
                         input int abort_at);
    int          len;
    logic [63:0] v;
    int unsigned upd0;
    bit          user;
    user = (m_ir == OP_USR);
    if (m_ir == OP_ID) begin len = 32; v = 64'(IDV); end
    else if (user)     begin len = USER_W; v = 64'(USER_DIN); end
    else               begin len = 1; v = '0; end
    upd0 = upd_cnt;
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        nRST = 1'b0;
        #1;
        check("rst_state", TAP_STATE, 0);
        check("rst_dout", USER_DOUT, 0);
        check("rst_oe", TDO_OE, 0);
        exp_q.delete();
        m_st = 0; m_ir = OP_ID; m_dout = '0;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_no_update", upd_cnt - upd0, 0);
        return;
      end
      exp_q.push_back(stream_bit(i, len, v, d));
      if (i == pause_at && i != n - 1) begin
        tck(1'b1, d[i]);
        tck(1'b0, 1'b0);
        tck(1'b0, 1'b0);
        tck(1'b1, 1'b0);
        tck(1'b0, 1'b0);
      end else begin
        tck(i == n - 1, d[i]);
      end
    end
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    if (user)
      for (int j = 0; j < int'(USER_W); j++) m_dout[j] = stream_bit(n + j, len, v, d);
    check("dr_q_drained", exp_q.size(), 0);
    check("user_dout", USER_DOUT, m_dout);
    check("update_pulses", upd_cnt - upd0, user ? 1 : 0);
  endtask

  task automatic rand_walk(input int steps);
    scb_en = 1'b0;
    for (int i = 0; i < steps; i++) tck(1'($urandom_range(0, 1)), 1'b0);
    goto_rti();
    scb_en = 1'b1;
  endtask

  initial begin
    logic [63:0] d;
    logic [IR_W-1:0] op;
    repeat (3) @(negedge CLK);
    check("reset_state", TAP_STATE, 0);
    check("reset_oe", TDO_OE, 0);
    check("reset_tdo", TDO_OUT, 0);
    check("reset_dout", USER_DOUT, 0);
    check("reset_update", USER_UPDATE, 0);
    nRST = 1'b1;
    repeat (3) @(negedge CLK);

    goto_rti();
    check("idle_oe", TDO_OE, 0);
    d = {$urandom, $urandom};
    scan_dr(32, d, -1, -1);

    scan_ir(4'b1111);
    scan_dr(4, 64'b1101, -1, -1);
    scan_ir(4'b0111);
    scan_dr(8, {$urandom, $urandom}, 3, -1);

    scan_ir(OP_USR);
    USER_DIN = 8'hA5;
    scan_dr(8, 64'h3C, -1, -1);
    check("user_3c", USER_DOUT, 8'h3C);

    for (int unsigned it = 0; it < 14; it++) begin
      if ($urandom_range(0, 2) == 0) rand_walk(int'($urandom_range(8, 30)));
      case ($urandom_range(0, 3))
        0:       op = OP_ID;
        1:       op = OP_USR;
        2:       op = '1;
        default: op = IR_W'($urandom);
      endcase
      USER_DIN = USER_W'($urandom);
      scan_ir(op);
      d = {$urandom, $urandom};
      scan_dr(int'($urandom_range(1, 40)), d,
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1, -1);
    end

    scan_ir(OP_USR);
    USER_DIN = 8'h5A;
    scan_dr(8, 64'hC3, -1, -1);
    scan_ir(OP_USR);
    scan_dr(8, 64'hFF, -1, 4);
    tck(1'b0, 1'b0);
    scan_dr(32, {$urandom, $urandom}, -1, -1);

    scan_ir(OP_USR);
    USER_DIN = 8'h96;
    scan_dr(8, 64'h69, -1, -1);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    check("in_pause", TAP_STATE, 6);
    nTRST_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
`ifdef JTAG_TRST_EN
    check("trst_state", TAP_STATE, 0);
    check("trst_oe", TDO_OE, 0);
    check("trst_dout_kept", USER_DOUT, 8'h69);
    nTRST_IN = 1'b1;
    repeat (4) @(negedge CLK);
    m_st = 0;
    m_ir = OP_ID;
    tck(1'b0, 1'b0);
    scan_dr(32, {$urandom, $urandom}, -1, -1);
`else
    repeat (3) @(negedge CLK);
    check("trst_ignored", TAP_STATE, 6);
    nTRST_IN = 1'b1;
    @(negedge CLK);
    tck(1'b1, 1'b0);
    tck(1'b1, 1'b0);
    tck(1'b0, 1'b0);
    m_dout = 8'h96;
    check("upd_after_pause", USER_DOUT, 8'h96);
`endif

    goto_rti();
    check("final_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
